// File: rtl/du_reg_way0.sv
// du_reg_way0 -- decode-to-execute pipeline register for way0.
//
// Two-entry skid buffer between the way0 decoder and the execute stage.
// The head entry drives the payload outputs directly. The skid entry
// catches one extra bundle while execute stalls. Because ready_o comes
// from a register, the execute ready never reaches the decoder/IFU in the
// same cycle.
//
// Optional feature: define DU_REG_STALL_CNT_EN to add stallCnt_o[31:0].
// It is a saturating count of cycles with valid_o && !ready_i. Only rst
// clears it; flush_i leaves it unchanged.
module du_reg_way0 #(
  parameter int PAYLOAD_W = 223,
  parameter int DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  // decoder side
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  rdAddr_i,
  input  logic        rdWriteEnable_i,
  input  logic [63:0] rs1ReadData_i,
  input  logic [63:0] rs2ReadData_i,
  input  logic [63:0] imm_i,
  input  logic [6:0]  opCode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [5:0]  shamt_i,
  input  logic [1:0]  way0_pID_i,
  // execute side
  output logic        valid_o,
  input  logic        ready_i,
  output logic [4:0]  rdAddr_o,
  output logic        rdWriteEnable_o,
  output logic [63:0] rs1ReadData_o,
  output logic [63:0] rs2ReadData_o,
  output logic [63:0] imm_o,
  output logic [6:0]  opCode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [5:0]  shamt_o,
  output logic [1:0]  way0_pID_o
`ifdef DU_REG_STALL_CNT_EN
  ,
  output logic [31:0] stallCnt_o
`endif
);

  // Occupancy encoding; the width follows DEPTH (2 entries -> 2 bits).
  typedef enum logic [$clog2(DEPTH+1)-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  occ_e                 state_q;
  logic                 valid_q;
  logic                 ready_q;
  logic [PAYLOAD_W-1:0] head_q;
  logic [PAYLOAD_W-1:0] skid_q;

  logic                 accept_s;
  logic                 issue_s;
  logic [PAYLOAD_W-1:0] in_payload_s;

  // Handshakes use the registered ready/valid only.
  assign accept_s = valid_i & ready_q;
  assign issue_s  = valid_q & ready_i;

  // Pack the incoming bundle. The field order matches the output unpacking.
  assign in_payload_s = {rdAddr_i, rdWriteEnable_i, rs1ReadData_i,
                         rs2ReadData_i, imm_i, opCode_i, funct3_i,
                         funct7_i, shamt_i, way0_pID_i};

  // Occupancy FSM, head/skid storage and the registered valid/ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      head_q  <= {PAYLOAD_W{1'b0}};
      skid_q  <= {PAYLOAD_W{1'b0}};
    end else if (flush_i) begin
      // Drop both entries and any same-cycle accept. An issue in this
      // cycle has already been seen by execute, so it completes.
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            head_q  <= in_payload_s;
            state_q <= ST_ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_s && !issue_s) begin
            // Execute stalled: park the new bundle behind the head.
            skid_q  <= in_payload_s;
            state_q <= ST_TWO;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (issue_s && !accept_s) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end else if (issue_s && accept_s) begin
            // Head leaves and the new bundle replaces it directly.
            head_q  <= in_payload_s;
            state_q <= ST_ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        ST_TWO: begin
          if (issue_s) begin
            // The skid entry moves up to head, which keeps FIFO order.
            head_q  <= skid_q;
            state_q <= ST_ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_TWO;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;

  // Payload outputs come straight from the head register.
  assign {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
          opCode_o, funct3_o, funct7_o, shamt_o, way0_pID_o} = head_q;

`ifdef DU_REG_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where execute back-pressures a valid bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (valid_q && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stallCnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_du_reg_way0.sv
// Directed, table-driven bench for du_reg_way0, plus hand-written
// sequences for the async reset and the optional stall counter.
module tb_du_reg_way0;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rdAddr_i;
  logic        rdWriteEnable_i;
  logic [63:0] rs1ReadData_i;
  logic [63:0] rs2ReadData_i;
  logic [63:0] imm_i;
  logic [6:0]  opCode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [5:0]  shamt_i;
  logic [1:0]  way0_pID_i;
  logic        valid_o;
  logic        ready_i;
  logic [4:0]  rdAddr_o;
  logic        rdWriteEnable_o;
  logic [63:0] rs1ReadData_o;
  logic [63:0] rs2ReadData_o;
  logic [63:0] imm_o;
  logic [6:0]  opCode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [5:0]  shamt_o;
  logic [1:0]  way0_pID_o;
`ifdef DU_REG_STALL_CNT_EN
  logic [31:0] stallCnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  du_reg_way0 dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .rdAddr_i        (rdAddr_i),
    .rdWriteEnable_i (rdWriteEnable_i),
    .rs1ReadData_i   (rs1ReadData_i),
    .rs2ReadData_i   (rs2ReadData_i),
    .imm_i           (imm_i),
    .opCode_i        (opCode_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .shamt_i         (shamt_i),
    .way0_pID_i      (way0_pID_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .rdAddr_o        (rdAddr_o),
    .rdWriteEnable_o (rdWriteEnable_o),
    .rs1ReadData_o   (rs1ReadData_o),
    .rs2ReadData_o   (rs2ReadData_o),
    .imm_o           (imm_o),
    .opCode_o        (opCode_o),
    .funct3_o        (funct3_o),
    .funct7_o        (funct7_o),
    .shamt_o         (shamt_o),
    .way0_pID_o      (way0_pID_o)
`ifdef DU_REG_STALL_CNT_EN
    ,
    .stallCnt_o      (stallCnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The other payload fields are derived from rd, so every field carries a
  // distinct, recognisable pattern for each bundle.
  function automatic logic [63:0] rs1_of(input logic [4:0] rd);
    return {32'hA5A5_A5A5, 27'd0, rd};
  endfunction
  function automatic logic [63:0] rs2_of(input logic [4:0] rd);
    return {32'h5A5A_5A5A, 27'd0, rd};
  endfunction
  function automatic logic [6:0] op_of(input logic [4:0] rd);
    return {2'b11, rd};
  endfunction
  function automatic logic [6:0] f7_of(input logic [4:0] rd);
    return {2'b01, ~rd};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic vld, input logic rdy, input logic fl,
                       input logic [4:0] rd, input logic [63:0] imm,
                       input logic [1:0] pid);
    valid_i         = vld;
    ready_i         = rdy;
    flush_i         = fl;
    rdAddr_i        = rd;
    rdWriteEnable_i = rd[0];
    rs1ReadData_i   = rs1_of(rd);
    rs2ReadData_i   = rs2_of(rd);
    imm_i           = imm;
    opCode_i        = op_of(rd);
    funct3_i        = rd[2:0];
    funct7_i        = f7_of(rd);
    shamt_i         = {1'b1, rd};
    way0_pID_i      = pid;
  endtask

  task automatic chk_payload(input string tag, input logic [4:0] rd,
                             input logic [63:0] imm, input logic [1:0] pid);
    chk({tag, ".rd"},    {59'd0, rdAddr_o},        {59'd0, rd});
    chk({tag, ".we"},    {63'd0, rdWriteEnable_o}, {63'd0, rd[0]});
    chk({tag, ".rs1"},   rs1ReadData_o,            rs1_of(rd));
    chk({tag, ".rs2"},   rs2ReadData_o,            rs2_of(rd));
    chk({tag, ".imm"},   imm_o,                    imm);
    chk({tag, ".op"},    {57'd0, opCode_o},        {57'd0, op_of(rd)});
    chk({tag, ".f3"},    {61'd0, funct3_o},        {61'd0, rd[2:0]});
    chk({tag, ".f7"},    {57'd0, funct7_o},        {57'd0, f7_of(rd)});
    chk({tag, ".shamt"}, {58'd0, shamt_o},         {58'd0, 1'b1, rd});
    chk({tag, ".pid"},   {62'd0, way0_pID_o},      {62'd0, pid});
  endtask

  task automatic chk_zero_payload(input string tag);
    chk({tag, ".rd0"},    {59'd0, rdAddr_o},        64'd0);
    chk({tag, ".we0"},    {63'd0, rdWriteEnable_o}, 64'd0);
    chk({tag, ".rs10"},   rs1ReadData_o,            64'd0);
    chk({tag, ".rs20"},   rs2ReadData_o,            64'd0);
    chk({tag, ".imm0"},   imm_o,                    64'd0);
    chk({tag, ".op0"},    {57'd0, opCode_o},        64'd0);
    chk({tag, ".f30"},    {61'd0, funct3_o},        64'd0);
    chk({tag, ".f70"},    {57'd0, funct7_o},        64'd0);
    chk({tag, ".shamt0"}, {58'd0, shamt_o},         64'd0);
    chk({tag, ".pid0"},   {62'd0, way0_pID_o},      64'd0);
  endtask

  // One cycle: inputs are already driven, then sample #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vld;
    logic        rdy;
    logic        fl;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [1:0]  pid;
    logic        e_vld;
    logic        e_rdy;
    logic [4:0]  e_rd;
    logic [63:0] e_imm;
    logic [1:0]  e_pid;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic rdy, input logic fl,
                              input logic [4:0] rd, input logic [63:0] imm,
                              input logic [1:0] pid, input logic e_vld,
                              input logic e_rdy, input logic [4:0] e_rd,
                              input logic [63:0] e_imm, input logic [1:0] e_pid);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.fl = fl; v.rd = rd; v.imm = imm; v.pid = pid;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_rd = e_rd; v.e_imm = e_imm;
    v.e_pid = e_pid;
    return v;
  endfunction

  vec_t vecs [22];

  initial begin
    // Expected values are the outputs right after the edge that consumes
    // the row's inputs. Payload is compared only when e_vld is 1.
    //              vld   rdy   fl    rd     imm                     pid    e_vld e_rdy e_rd   e_imm                   e_pid
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 5'd3,  64'h10,                 2'd0, 1'b1, 1'b1, 5'd3,  64'h10,                 2'd0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 5'd4,  64'hFFFF_FFFF_FFFF_FFF4, 2'd1, 1'b1, 1'b1, 5'd4,  64'hFFFF_FFFF_FFFF_FFF4, 2'd1);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 5'd5,  64'h8000_0000_0000_0005, 2'd2, 1'b1, 1'b1, 5'd5,  64'h8000_0000_0000_0005, 2'd2);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 5'd6,  64'h66,                 2'd0, 1'b1, 1'b1, 5'd6,  64'h66,                 2'd0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 5'd7,  64'h77,                 2'd1, 1'b1, 1'b0, 5'd6,  64'h66,                 2'd0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 5'd8,  64'h88,                 2'd2, 1'b1, 1'b0, 5'd6,  64'h66,                 2'd0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b1, 1'b1, 5'd7,  64'h77,                 2'd1);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 5'd9,  64'h99,                 2'd3, 1'b1, 1'b1, 5'd9,  64'h99,                 2'd3);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 5'd10, 64'hAA,                 2'd0, 1'b1, 1'b1, 5'd10, 64'hAA,                 2'd0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b1, 1'b1, 5'd10, 64'hAA,                 2'd0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 5'd11, 64'hBB,                 2'd1, 1'b1, 1'b1, 5'd11, 64'hBB,                 2'd1);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 5'd12, 64'hCC,                 2'd2, 1'b1, 1'b0, 5'd11, 64'hBB,                 2'd1);
    vecs[16] = mk(1'b1, 1'b0, 1'b1, 5'd13, 64'hDD,                 2'd3, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 5'd14, 64'hEE,                 2'd0, 1'b1, 1'b1, 5'd14, 64'hEE,                 2'd0);
    vecs[19] = mk(1'b0, 1'b1, 1'b1, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 5'd15, 64'hFF,                 2'd1, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);
    vecs[21] = mk(1'b0, 1'b1, 1'b0, 5'd0,  64'd0,                  2'd0, 1'b0, 1'b1, 5'd0,  64'd0,                  2'd0);

    // Reset state.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    #2;
    chk("rst.valid", {63'd0, valid_o}, 64'd0);
    chk("rst.ready", {63'd0, ready_o}, 64'd0);
    chk_zero_payload("rst");
    step();
    rst = 1'b0;
    #1;
    chk("rel.ready_pre_edge", {63'd0, ready_o}, 64'd0);

    // Table of streaming, stall, ONE-with-both and flush cases.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].vld, vecs[i].rdy, vecs[i].fl, vecs[i].rd, vecs[i].imm, vecs[i].pid);
      step();
      chk($sformatf("vec%0d.valid", i), {63'd0, valid_o}, {63'd0, vecs[i].e_vld});
      chk($sformatf("vec%0d.ready", i), {63'd0, ready_o}, {63'd0, vecs[i].e_rdy});
      if (vecs[i].e_vld)
        chk_payload($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_imm, vecs[i].e_pid);
    end

    // Async reset while holding two bundles.
    drive(1'b1, 1'b0, 1'b0, 5'd16, 64'h1616, 2'd2);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd17, 64'h1717, 2'd3);
    step();
    chk("stall2.ready", {63'd0, ready_o}, 64'd0);
    chk_payload("stall2", 5'd16, 64'h1616, 2'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.valid", {63'd0, valid_o}, 64'd0);
    chk("arst.ready", {63'd0, ready_o}, 64'd0);
    chk_zero_payload("arst");
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 2'd0);
    step();
    chk("arst_hold.ready", {63'd0, ready_o}, 64'd0);
    rst = 1'b0;
    #1;
    chk("arst_rel.ready_pre_edge", {63'd0, ready_o}, 64'd0);
    step();
    chk("arst_rel.ready", {63'd0, ready_o}, 64'd1);
    chk("arst_rel.valid", {63'd0, valid_o}, 64'd0);
    step();
    chk("arst_nosurvive.valid", {63'd0, valid_o}, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 5'd18, 64'h1818, 2'd1);
    step();
    chk("arst_new.valid", {63'd0, valid_o}, 64'd1);
    chk_payload("arst_new", 5'd18, 64'h1818, 2'd1);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 2'd0);
    step();
    chk("arst_drain.valid", {63'd0, valid_o}, 64'd0);

`ifdef DU_REG_STALL_CNT_EN
    // Stall counter: 7 back-pressured cycles, then saturation.
    rst = 1'b1;
    #1;
    chk("scnt.rst", {32'd0, stallCnt_o}, 64'd0);
    step();
    rst = 1'b0;
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd19, 64'h1919, 2'd0);
    step();
    chk("scnt.after_accept", {32'd0, stallCnt_o}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    for (int k = 0; k < 7; k++) step();
    chk("scnt.seven", {32'd0, stallCnt_o}, 64'd7);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 64'd0, 2'd0);
    step();
    chk("scnt.flush_keeps", {32'd0, stallCnt_o}, 64'd8);
    drive(1'b1, 1'b0, 1'b0, 5'd20, 64'h2020, 2'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    step();
    chk("scnt.fe", {32'd0, stallCnt_o}, {32'd0, 32'hFFFF_FFFE});
    step();
    chk("scnt.ff", {32'd0, stallCnt_o}, {32'd0, 32'hFFFF_FFFF});
    step();
    step();
    chk("scnt.sat", {32'd0, stallCnt_o}, {32'd0, 32'hFFFF_FFFF});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
